// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO; results land 33 enabled cycles after accept.
// No input handshake: requests are taken only in IDLE with clk_enable high, all others are dropped; clk_enable low stalls.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        op_start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [64:0] r_prod;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_div;
    logic        r_dz;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // op[0]==0 selects the signed variants (MULT, DIV)
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_neg_q;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_sub;
    logic        w_div_ge;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_a_neg     = ~op[0] & operand_a[31];
    assign w_b_neg     = ~op[0] & operand_b[31];
    assign w_neg_q     = w_a_neg ^ w_b_neg;
    assign w_abs_a     = w_a_neg ? -operand_a : operand_a;
    assign w_abs_b     = w_b_neg ? -operand_b : operand_b;

    // r_prod: mul = {partial high, multiplier shifting out}; div = {remainder, dividend shifting into quotient}
    assign w_mul_sum   = r_prod[64:32] + (r_prod[0] ? {1'b0, r_a} : 33'd0);
    assign w_div_shift = r_prod[63:31];
    assign w_div_ge    = w_div_shift >= {1'b0, r_a};
    assign w_div_sub   = w_div_shift - {1'b0, r_a};

    assign w_prod_fix  = r_neg_q ? -r_prod[63:0]  : r_prod[63:0];
    assign w_quo_fix   = r_neg_q ? -r_prod[31:0]  : r_prod[31:0];
    assign w_rem_fix   = r_neg_r ? -r_prod[63:32] : r_prod[63:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_prod   <= 65'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (clk_enable) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (op_start) begin
                            case (op)
                                3'b100: r_hi <= operand_a;
                                3'b101: r_lo <= operand_a;
                                3'b000, 3'b001: begin
                                    r_a      <= w_abs_a;
                                    r_prod   <= {33'd0, w_abs_b};
                                    r_neg_q  <= w_neg_q;
                                    r_neg_r  <= 1'b0;
                                    r_is_div <= 1'b0;
                                    r_dz     <= 1'b0;
                                    r_cnt    <= 5'd0;
                                    r_busy   <= 1'b1;
                                    r_state  <= S_MUL;
                                end
                                3'b010, 3'b011: begin
                                    r_a      <= w_abs_b;
                                    r_prod   <= {33'd0, w_abs_a};
                                    r_neg_q  <= w_neg_q;
                                    r_neg_r  <= w_a_neg;
                                    r_is_div <= 1'b1;
                                    r_dz     <= (operand_b == 32'd0);
                                    r_cnt    <= 5'd0;
                                    r_busy   <= 1'b1;
                                    r_state  <= S_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        r_prod <= {1'b0, w_mul_sum, r_prod[31:1]};
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= S_FIX;
                    end
                    S_DIV: begin
                        r_prod <= {(w_div_ge ? w_div_sub : w_div_shift), r_prod[30:0], w_div_ge};
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        // divide-by-zero leaves remainder = |dividend|, so sign correction restores the dividend
                        if (r_is_div) begin
                            r_lo <= r_dz ? 32'hFFFF_FFFF : w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, stall, drop and reset-abort cases.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        op_start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .op_start   (op_start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one iterative op and follow it to completion; optional stall window and a dropped MTHI while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int stall_at, input int stall_len,
                          input int drop_at);
        int lat;
        int busy_cnt;
        int bad;
        lat = 33 + stall_len;
        @(negedge clk);
        op_start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        op_start = 1'b0; operand_a = ~a; operand_b = 32'h0000_0005;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        busy_cnt = 1;
        bad = 0;
        for (int k = 1; k < lat; k++) begin
            op_start = 1'b0;
            @(posedge clk); #1;
            if (done || hi !== m_hi || lo !== m_lo) bad++;
            if (busy) busy_cnt++;
            if (k == stall_at) clk_enable = 1'b0;
            if (k == stall_at + stall_len) clk_enable = 1'b1;
            if (k == drop_at) begin
                op_start = 1'b1; op = 3'b100; operand_a = 32'h1234_5678;
            end
        end
        op_start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_busy_cycles"}, busy_cnt, lat);
        chk({tag, "_inflight_clean"}, bad, 32'd0);
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
    endtask

    task automatic move_op(input string tag, input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        op_start = 1'b1; op = o; operand_a = a;
        @(posedge clk); #1;
        op_start = 1'b0;
        if (o == 3'b100) m_hi = a;
        if (o == 3'b101) m_lo = a;
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen_done;
        n_checks = 0; n_errors = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b0; clk_enable = 1'b1; op_start = 1'b0; op = 3'b000;
        operand_a = 32'd0; operand_b = 32'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b1;

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, 0, 12);
        chk("drop_mthi_hi", hi, 32'hFFFF_FFFF);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 0, -1);
        run_op("multu_sh", 3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, -1, 0, -1);
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 0, -1);
        run_op("divu_by0", 3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("div_by0", 3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1, 0, -1);
        run_op("divu_100_7", 3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, -1, 0, -1);
        run_op("mult_stall", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 10, 5, -1);

        move_op("mthi_idle", 3'b100, 32'h1234_5678);
        move_op("mtlo_idle", 3'b101, 32'hCAFE_F00D);
        move_op("op_110", 3'b110, 32'hDEAD_BEEF);

        // reset in the middle of a DIV
        @(negedge clk);
        op_start = 1'b1; op = 3'b010; operand_a = 32'h0000_0064; operand_b = 32'h0000_0003;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        chk("abort_no_done", seen_done, 32'd0);
        chk("abort_hi_after", hi, 32'd0);

        // first edge after release accepts a request
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; op_start = 1'b1; op = 3'b101; operand_a = 32'h0BAD_F00D;
        @(posedge clk); #1;
        op_start = 1'b0;
        chk("post_rst_mtlo", lo, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; all datapaths are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; this is the only reset.
REQ-004 clk_enable  in  1  high: the block may advance; low: all state frozen.
REQ-005 op_start  in  1  request strobe, sampled on rising clk.
REQ-006 op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-007 operand_a  in  32  rs value from the register file (read_data_a).
REQ-008 operand_b  in  32  rt value from the register file (read_data_b).
REQ-009 busy  out  1  high while an iterative operation is in progress.
REQ-010 done  out  1  one-cycle pulse when HI/LO receive a multiply or divide result.
REQ-011 hi  out  32  architectural HI register (MFHI source).
REQ-012 lo  out  32  architectural LO register (MFLO source).

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX; the block leaves reset in IDLE.
REQ-014 A request SHALL be accepted only when state=IDLE, op_start=1 and clk_enable=1; requests in any other state are dropped without side effects.
REQ-015 MTHI/MTLO SHALL write operand_a to hi/lo on the accepting edge; state stays IDLE; busy and done stay 0.
REQ-016 MULT/MULTU/DIV/DIVU SHALL latch operands on the accepting edge and enter MUL or DIV; busy rises on that edge.
REQ-017 Signed ops SHALL latch absolute values plus result-sign flags; unsigned ops SHALL latch operands unchanged.
REQ-018 MUL SHALL run one shift-add step per enabled cycle for exactly 32 steps, then go to FIX.
REQ-019 DIV SHALL run one restoring-division step per enabled cycle for exactly 32 steps, then go to FIX.
REQ-020 FIX SHALL apply the sign correction, write hi/lo, pulse done, drop busy and return to IDLE, all on one edge.
REQ-021 Latency: accept edge N; hi/lo/done update on edge N+33, with clk_enable high throughout; busy is high for exactly 33 cycles.
REQ-022 Each cycle with clk_enable=0 SHALL add one cycle to the latency; counter, partial results and outputs hold.
REQ-023 MULT/MULTU SHALL set {hi,lo} to the full 64-bit two's-complement or unsigned product.
REQ-024 DIV/DIVU SHALL set lo = quotient and hi = remainder; signed quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-025 Division by zero SHALL take full latency and set lo=0xFFFFFFFF, hi=dividend (as given, unsigned or signed).
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL set lo=0x80000000, hi=0x00000000.
REQ-027 hi/lo SHALL be unchanged from accept until the FIX edge; results of an in-flight op are never partially visible.
REQ-028 Operand inputs SHALL be ignored after the accepting edge.
REQ-029 done SHALL be 0 in every cycle other than the one following the FIX edge.

Reset
REQ-030 Asserting reset SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the step counter immediately, independent of clk.
REQ-031 Reset asserted mid-operation SHALL abort it; no result is written after release.
REQ-032 After release, the first rising edge SHALL be able to accept a new request.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> 33 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 cycles.
REQ-035 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-036 MTHI 0x12345678 during busy -> dropped, hi unchanged; the same op issued in IDLE -> hi=0x12345678 next edge, busy stays 0.
REQ-037 clk_enable held low for 5 cycles mid-MULT -> result appears on edge N+38 with the correct value.
REQ-038 reset pulsed low at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately; no done pulse follows.
